// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling, 3-sample majority
// vote per bit, and a small first-word-fall-through byte FIFO on the output.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   rx         asynchronous serial line, idles high
//   rd_en      pop request (ignored while rd_valid=0)
//   rd_data    FIFO head byte, valid while rd_valid=1
//   rd_valid   FIFO not empty
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    one-cycle pulse: good byte dropped because the FIFO was full
//   rx_busy    receiver is inside a frame (START, DATA or STOP)
//
// Read handshake: rd_data is the head entry whenever rd_valid=1; a byte is
// consumed on every rising clk edge where rd_valid=1 and rd_en=1. rd_en while
// rd_valid=0 has no effect. A push and a pop on the same edge leave the
// occupancy unchanged, so a full FIFO can still accept a byte if it is popped
// on that very edge.
module uart_rx_fifo #(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_busy
);

   // Clocks per oversample tick, rounded to nearest.
   localparam int DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic             rx_meta, rxs;
   logic [3:0]       s;
   logic [2:0]       samp;
   logic [2:0]       idx;
   logic [7:0]       shreg;
   logic             armed;

   logic             s_clr, idx_clr, shift_en, armed_set, armed_clr;
   logic             push, fe_set, ov_set;
   logic             vote_full, vote_stop;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             full, pop;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Free-running oversample tick.
   assign tick = (div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset)     div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DIV_W'(1);
   end

   // Two-flop synchronizer; everything downstream looks only at rxs.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // START/DATA decide at s=15 using all three captured samples. STOP decides
   // at s=9, so its third sample is the live rxs of that same tick.
   assign vote_full = maj3(samp[0], samp[1], samp[2]);
   assign vote_stop = maj3(samp[0], samp[1], rxs);

   assign rx_busy = (state != IDLE);
   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign pop     = rd_en && rd_valid;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      s_clr     = 1'b0;
      idx_clr   = 1'b0;
      shift_en  = 1'b0;
      armed_set = 1'b0;
      armed_clr = 1'b0;
      push      = 1'b0;
      fe_set    = 1'b0;
      ov_set    = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick) begin
               if (rxs) begin
                  armed_set = 1'b1;
               end else if (armed) begin
                  state_nxt = START;
                  s_clr     = 1'b1;
               end
            end
         end
         START: begin
            if (tick && s == 4'd15) begin
               if (!vote_full) begin
                  state_nxt = DATA;
                  s_clr     = 1'b1;
                  idx_clr   = 1'b1;
               end else begin
                  // Too short to be a start bit; armed stays set.
                  state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            // s wraps 15 -> 0 by itself between data bits.
            if (tick && s == 4'd15) begin
               shift_en = 1'b1;
               if (idx == 3'd7) begin
                  state_nxt = STOP;
                  s_clr     = 1'b1;
               end
            end
         end
         STOP: begin
            if (tick && s == 4'd9) begin
               state_nxt = IDLE;
               if (vote_stop) begin
                  if (!full || pop) push   = 1'b1;
                  else              ov_set = 1'b1;
               end else begin
                  // A low line (break) must go high before a new frame starts.
                  fe_set    = 1'b1;
                  armed_clr = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s         <= '0;
         samp      <= '0;
         idx       <= '0;
         shreg     <= '0;
         armed     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= fe_set;
         overrun   <= ov_set;
         if (armed_clr)      armed <= 1'b0;
         else if (armed_set) armed <= 1'b1;
         if (s_clr)                s <= '0;
         else if (tick && rx_busy) s <= s + 4'd1;
         if (tick && rx_busy) begin
            case (s)
               4'd7:    samp[0] <= rxs;
               4'd8:    samp[1] <= rxs;
               4'd9:    samp[2] <= rxs;
               default: ;
            endcase
         end
         if (idx_clr)       idx <= '0;
         else if (shift_en) idx <= idx + 3'd1;
         // LSB arrives first, so shift in from the top.
         if (shift_en) shreg <= {vote_full, shreg[7:1]};
      end
   end

   // FIFO storage; pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
   end

   assign rd_data  = mem[rd_ptr];
   assign rd_valid = (count != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives 8N1 frames into uart_rx_fifo at DIV=10 (160 clk per
// bit) and checks every output on every cycle against a frame-level model.
module tb_uart_rx_fifo;

   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 10000;
   localparam int DEPTH  = 4;
   localparam int DIV    = 10;
   localparam int BIT    = 16 * DIV;
   // Ticks from start detection to the STOP decision: 16 (start) + 8*16 (data) + 10.
   localparam int FRAME_TICKS = 16 + 8 * 16 + 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid, frame_err, overrun, rx_busy;

   uart_rx_fifo #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .frame_err(frame_err),
      .overrun(overrun), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   // kind: 1 = frame with good stop bit, 2 = stop bit low, 3 = glitch
   typedef struct {
      int         t0;
      int         t_end;
      int         kind;
      logic [7:0] data;
   } ev_t;

   int         tests_run = 0;
   int         tests_failed = 0;
   int         cyc = 0;
   ev_t        ev_q[$];
   logic [7:0] exp_q[$];
   logic       exp_fe = 1'b0;
   logic       exp_ov = 1'b0;
   logic       exp_busy;
   logic       m_pop, m_full;
   int         last_t_end = 0;
   int         fe_seen = 0;
   int         ov_seen = 0;
   int         busy_seen = 0;
   logic [11:0] act_v, exp_v;
   logic       rand_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model, advanced on each rising edge. cyc counts edges since
   // the last edge that saw reset high; the oversample tick lands on edges
   // where cyc is a nonzero multiple of DIV.
   initial forever begin
      @(posedge clk);
      if (reset) begin
         cyc = 0;
         exp_q.delete();
         ev_q.delete();
         exp_fe = 1'b0;
         exp_ov = 1'b0;
      end else begin
         cyc++;
         exp_fe = 1'b0;
         exp_ov = 1'b0;
         m_full = (exp_q.size() == DEPTH);
         m_pop  = rd_en && (exp_q.size() != 0);
         if (m_pop) void'(exp_q.pop_front());
         if (ev_q.size() != 0 && ev_q[0].t_end == cyc) begin
            if (ev_q[0].kind == 1) begin
               if (!m_full || m_pop) exp_q.push_back(ev_q[0].data);
               else                  exp_ov = 1'b1;
            end else if (ev_q[0].kind == 2) begin
               exp_fe = 1'b1;
            end
            void'(ev_q.pop_front());
         end
      end
   end

   // Compare process: all outputs, every cycle outside reset.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         exp_busy = (ev_q.size() != 0) && (cyc >= ev_q[0].t0) && (cyc < ev_q[0].t_end);
         act_v = {rd_valid, (exp_q.size() != 0) ? rd_data : 8'h00, frame_err, overrun, rx_busy};
         exp_v = {exp_q.size() != 0, (exp_q.size() != 0) ? exp_q[0] : 8'h00, exp_fe, exp_ov, exp_busy};
         check("cycle {valid,data,fe,ov,busy}", 32'(act_v), 32'(exp_v));
         fe_seen   += int'(frame_err);
         ov_seen   += int'(overrun);
         busy_seen += int'(rx_busy);
      end
   end

   // Schedule the model event for a frame whose start edge is driven now.
   // The 2-flop synchronizer makes the low level decidable 3 edges later;
   // detection then waits for the next tick.
   task automatic schedule(input int kind, input logic [7:0] d);
      ev_t ev;
      ev.t0    = ((cyc + 3 + DIV - 1) / DIV) * DIV;
      ev.t_end = ev.t0 + ((kind == 3) ? 16 * DIV : FRAME_TICKS * DIV);
      ev.kind  = kind;
      ev.data  = d;
      ev_q.push_back(ev);
      last_t_end = ev.t_end;
   endtask

   task automatic drive_frame(input logic [7:0] d, input logic stop, input int nbits);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      @(posedge clk); #1;
      schedule(stop ? 1 : 2, d);
      for (int i = 0; i < nbits; i++) begin
         rx = bits[i];
         repeat (BIT) @(posedge clk);
         #1;
      end
   endtask

   task automatic glitch(input int len);
      @(posedge clk); #1;
      schedule(3, 8'h00);
      rx = 1'b0;
      repeat (len) @(posedge clk);
      #1;
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic read_one(input logic [7:0] lit, input string name);
      @(negedge clk);
      check({name, " valid"}, 32'(rd_valid), 32'd1);
      check(name, 32'(rd_data), 32'(lit));
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   initial begin
      #(10 * 95000);
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe0, ov0, busy0, guard;
      logic [7:0] fill [4];

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset rd_data", 32'(rd_data), 32'h00);
      check("reset frame_err", 32'(frame_err), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset rx_busy", 32'(rx_busy), 32'd0);
      idle(200);

      // Single byte, then one read empties the FIFO.
      drive_frame(8'h41, 1'b1, 10);
      idle(20);
      check("t1 model size", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) check("t1 model head", 32'(exp_q[0]), 32'h41);
      read_one(8'h41, "t1 data");
      @(negedge clk);
      check("t1 empty after read", 32'(rd_valid), 32'd0);

      // Five bytes with no reads: fifth is dropped with one overrun pulse.
      ov0 = ov_seen;
      drive_frame(8'h55, 1'b1, 10);
      drive_frame(8'hAA, 1'b1, 10);
      drive_frame(8'h0D, 1'b1, 10);
      drive_frame(8'h7E, 1'b1, 10);
      drive_frame(8'h31, 1'b1, 10);
      idle(20);
      check("t2 overrun count", 32'(ov_seen - ov0), 32'd1);
      read_one(8'h55, "t2 byte0");
      read_one(8'hAA, "t2 byte1");
      read_one(8'h0D, "t2 byte2");
      read_one(8'h7E, "t2 byte3");
      @(negedge clk);
      check("t2 empty", 32'(rd_valid), 32'd0);

      // Full FIFO, pop on the exact push edge of a fifth byte.
      for (int i = 0; i < 4; i++) begin
         fill[i] = 8'($urandom_range(0, 255));
         drive_frame(fill[i], 1'b1, 10);
      end
      ov0 = ov_seen;
      guard = 0;
      fork
         drive_frame(8'h62, 1'b1, 10);
         begin
            @(posedge clk); #2;
            while (cyc != last_t_end - 1 && guard < 4000) begin
               @(negedge clk);
               guard++;
            end
            rd_en = 1'b1;
            @(posedge clk); #1;
            rd_en = 1'b0;
         end
      join
      idle(20);
      check("t3 push-edge found", 32'(guard < 4000), 32'd1);
      check("t3 no overrun", 32'(ov_seen - ov0), 32'd0);
      read_one(fill[1], "t3 byte1");
      read_one(fill[2], "t3 byte2");
      read_one(fill[3], "t3 byte3");
      read_one(8'h62, "t3 byte 0x62");
      @(negedge clk);
      check("t3 empty", 32'(rd_valid), 32'd0);

      // Stop bit low, line held low, then high; next frame must be clean.
      fe0 = fe_seen;
      drive_frame(8'h48, 1'b0, 10);
      repeat (400) @(posedge clk);
      #1;
      idle(320);
      check("t4 frame_err count", 32'(fe_seen - fe0), 32'd1);
      check("t4 no push", 32'(rd_valid), 32'd0);
      drive_frame(8'h69, 1'b1, 10);
      idle(20);
      read_one(8'h69, "t4 byte 0x69");

      // 48-clk glitch on an idle line.
      fe0 = fe_seen;
      ov0 = ov_seen;
      busy0 = busy_seen;
      glitch(48);
      idle(300);
      check("t5 no frame_err", 32'(fe_seen - fe0), 32'd0);
      check("t5 no overrun", 32'(ov_seen - ov0), 32'd0);
      check("t5 no push", 32'(rd_valid), 32'd0);
      check("t5 busy within one bit", 32'((busy_seen - busy0) > 0 && (busy_seen - busy0) <= BIT), 32'd1);

      // Reset during DATA with two bytes queued.
      drive_frame(8'h12, 1'b1, 10);
      drive_frame(8'h9C, 1'b1, 10);
      fe0 = fe_seen;
      drive_frame(8'h33, 1'b1, 4);
      rx = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("t6 rd_valid after reset", 32'(rd_valid), 32'd0);
      check("t6 rx_busy after reset", 32'(rx_busy), 32'd0);
      check("t6 rd_data after reset", 32'(rd_data), 32'h00);
      idle(200);
      drive_frame(8'h34, 1'b1, 10);
      idle(20);
      check("t6 no frame_err", 32'(fe_seen - fe0), 32'd0);
      read_one(8'h34, "t6 byte 0x34");

      // Random bytes, occasional bad stop bits, random reads.
      rand_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 8; n++) begin
               logic [7:0] d;
               logic       st;
               d  = 8'($urandom_range(0, 255));
               st = ($urandom_range(0, 7) != 0);
               drive_frame(d, st, 10);
               if (!st) idle(200);
               else     idle($urandom_range(0, 120));
            end
            idle(20);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               rd_en = ($urandom_range(0, 3) == 0);
            end
            rd_en = 1'b0;
         end
      join
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         rd_en = 1'b1;
         @(posedge clk); #1;
         rd_en = 1'b0;
      end
      @(negedge clk);
      check("random drained", 32'(rd_valid), 32'd0);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
